// File: rtl/patp_ctrl.sv
// PATP fetch/decode/execute control sequencer.
// Owns PC and IR, runs the request/ack handshake to the unified program/data
// memory, and steers the external D0 accumulator (ALU op select + load strobe).
module patp_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] d0_q,
  output logic [1:0]        alu_op,
  output logic              d0_we,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_JMP   = 3'd4;
  localparam logic [2:0] OP_JZ    = 3'd5;
  localparam logic [2:0] OP_NOP   = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  state_t              state_r, state_nxt_s;
  logic [ADDR_W-1:0]   pc_r, pc_nxt_s;
  logic [DATA_W-1:0]   ir_r, ir_nxt_s;
  logic [2:0]          op_s;
  logic [ADDR_W-1:0]   opnd_s;
  logic                req_s, we_s, dwe_s, halted_s;
  logic [ADDR_W-1:0]   addr_s;
  logic [1:0]          alu_op_s;

  assign op_s   = ir_r[DATA_W-1 -: 3];
  assign opnd_s = ir_r[ADDR_W-1:0];

  // State, program counter and instruction register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_FETCH;
      pc_r    <= {ADDR_W{1'b0}};
      ir_r    <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      ir_r    <= ir_nxt_s;
    end
  end

  // Next-state, PC/IR update and handshake/ALU control per state.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    ir_nxt_s    = ir_r;
    req_s       = 1'b0;
    we_s        = 1'b0;
    addr_s      = pc_r;
    alu_op_s    = 2'b00;
    dwe_s       = 1'b0;
    halted_s    = 1'b0;
    case (state_r)
      ST_FETCH: begin
        req_s  = 1'b1;
        addr_s = pc_r;
        if (mem_ack) begin
          ir_nxt_s    = mem_rdata;
          pc_nxt_s    = pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          state_nxt_s = ST_DECODE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (op_s)
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB: state_nxt_s = ST_EXEC;
          OP_JMP: begin
            pc_nxt_s    = opnd_s;
            state_nxt_s = ST_FETCH;
          end
          OP_JZ: begin
            if (d0_q == {DATA_W{1'b0}}) begin
              pc_nxt_s = opnd_s;
            end else begin
              pc_nxt_s = pc_r;
            end
            state_nxt_s = ST_FETCH;
          end
          OP_NOP:  state_nxt_s = ST_FETCH;
          OP_HALT: state_nxt_s = ST_HALT;
          default: state_nxt_s = ST_FETCH;
        endcase
      end
      ST_EXEC: begin
        req_s  = 1'b1;
        addr_s = opnd_s;
        we_s   = (op_s == OP_STORE);
        case (op_s)
          OP_LOAD: alu_op_s = 2'b00;
          OP_ADD:  alu_op_s = 2'b01;
          OP_SUB:  alu_op_s = 2'b10;
          default: alu_op_s = 2'b00;
        endcase
        dwe_s = mem_ack & ((op_s == OP_LOAD) | (op_s == OP_ADD) | (op_s == OP_SUB));
        if (mem_ack) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_HALT: begin
        halted_s    = 1'b1;
        state_nxt_s = ST_HALT;
      end
      default: state_nxt_s = ST_FETCH;
    endcase
  end

  // Request, write and D0 strobes are cut by rst so nothing completes after it rises.
  assign mem_req  = req_s & ~rst;
  assign mem_we   = we_s & ~rst;
  assign d0_we    = dwe_s & ~rst;
  assign halted   = halted_s & ~rst;
  assign mem_addr = addr_s;
  assign alu_op   = alu_op_s;
  assign pc       = pc_r;

endmodule

// File: tb/tb_patp_ctrl.sv
// Self-checking bench for patp_ctrl: an environment (memory + D0 register driven
// by the DUT) is compared against an instruction-level ISA model.
module tb_patp_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_req, mem_we, mem_ack = 1'b0;
  logic [4:0] mem_addr, pc;
  logic [7:0] mem_rdata = 8'h00, d0_q = 8'h00;
  logic [1:0] alu_op;
  logic       d0_we, halted;

  patp_ctrl #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .d0_q(d0_q), .alu_op(alu_op),
    .d0_we(d0_we), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  // environment state (changed only through DUT actions)
  logic [7:0] mem [32];
  logic [7:0] d0;
  // ISA reference model
  logic [7:0] mmem [32];
  logic [7:0] md0;
  int         mpc;
  bit         mhalt;

  int checks = 0, failures = 0;
  int wfix = 0, wmax = 0;
  logic       s_req, s_we, s_dwe, s_halt;
  logic [4:0] s_addr, s_pc;
  logic [1:0] s_op;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory response at negedge, sample, apply env updates at posedge.
  task automatic cycle(input logic ack);
    @(negedge clk);
    mem_ack   = ack;
    mem_rdata = mem[mem_addr];
    d0_q      = d0;
    #1;
    s_req = mem_req; s_we = mem_we; s_dwe = d0_we; s_halt = halted;
    s_addr = mem_addr; s_pc = pc; s_op = alu_op;
    @(posedge clk);
    if (s_req && ack && s_we) mem[s_addr] = d0;
    if (s_dwe) begin
      case (s_op)
        2'b00:   d0 = mem_rdata;
        2'b01:   d0 = d0 + mem_rdata;
        2'b10:   d0 = d0 - mem_rdata;
        default: d0 = 8'hXX;
      endcase
    end
  endtask

  task automatic do_txn(input string tag, input int addr, input bit we, input bit dwe,
                        input int aop, input bit is_fetch);
    int n;
    n = (wfix >= 0) ? wfix : $urandom_range(wmax, 0);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0);
      check({tag, "_wait_req"}, s_req, 1);
      check({tag, "_wait_addr"}, s_addr, addr);
      check({tag, "_wait_we"}, s_we, we);
      check({tag, "_wait_d0we"}, s_dwe, 0);
    end
    cycle(1'b1);
    check({tag, "_req"}, s_req, 1);
    check({tag, "_addr"}, s_addr, addr);
    check({tag, "_we"}, s_we, we);
    check({tag, "_d0we"}, s_dwe, dwe);
    if (dwe) check({tag, "_aluop"}, s_op, aop);
    if (is_fetch) check({tag, "_pc"}, s_pc, addr);
  endtask

  task automatic idle(input bit exp_halt);
    cycle(1'($urandom_range(1, 0)));
    check("idle_req", s_req, 0);
    check("idle_d0we", s_dwe, 0);
    check("idle_halted", s_halt, exp_halt);
  endtask

  // Execute one instruction of the model and check the DUT transactions it implies.
  task automatic step();
    logic [7:0] ins;
    int op, a;
    ins = mmem[mpc];
    op  = int'(ins[7:5]);
    a   = int'(ins[4:0]);
    do_txn("fetch", mpc, 1'b0, 1'b0, 0, 1'b1);
    mpc = (mpc + 1) % 32;
    idle(1'b0);
    case (op)
      0, 2, 3: begin
        do_txn("exec", a, 1'b0, 1'b1, (op == 0) ? 0 : op - 1, 1'b0);
        if (op == 0)      md0 = mmem[a];
        else if (op == 2) md0 = 8'((int'(md0) + int'(mmem[a])) % 256);
        else              md0 = 8'((int'(md0) - int'(mmem[a]) + 256) % 256);
      end
      1: begin
        do_txn("store", a, 1'b1, 1'b0, 0, 1'b0);
        mmem[a] = md0;
        check("store_mem", mem[a], mmem[a]);
      end
      4: mpc = a;
      5: if (md0 == 8'h00) mpc = a;
      6: ;
      default: begin
        mhalt = 1'b1;
        repeat (5) idle(1'b1);
      end
    endcase
    check("d0", d0, md0);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    mem_ack = 1'b0;
    #1;
    check("rst_req", mem_req, 0);
    check("rst_d0we", d0_we, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 0);
    @(negedge clk);
    rst = 1'b0;
    mpc = 0;
    mhalt = 1'b0;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 32; i++) mem[i] = 8'hC0;
  endtask

  task automatic sync_model();
    for (int i = 0; i < 32; i++) mmem[i] = mem[i];
    md0 = d0;
  endtask

  initial begin
    d0 = 8'h00;
    fill_nop();
    repeat (2) @(negedge clk);

    // LOAD with zero-wait memory
    do_reset();
    wfix = 0;
    fill_nop(); mem[0] = 8'h05; mem[5] = 8'h2A; d0 = 8'h00; sync_model();
    step();
    check("load_val", d0, 8'h2A);
    cycle(1'b0);
    check("load_pc", s_pc, 1);

    // ADD wraps, SUB underflows
    do_reset();
    fill_nop();
    mem[0] = 8'h0A; mem[1] = 8'h4B; mem[2] = 8'h0C; mem[3] = 8'h6D;
    mem[10] = 8'hF0; mem[11] = 8'h20; mem[12] = 8'h00; mem[13] = 8'h01;
    sync_model();
    step(); step();
    check("add_wrap", d0, 8'h10);
    step(); step();
    check("sub_wrap", d0, 8'hFF);

    // JZ taken / not taken, JMP to 0x1F, PC wrap
    do_reset();
    fill_nop();
    mem[0] = 8'h14; mem[1] = 8'hBC; mem[20] = 8'h00; mem[21] = 8'h01;
    mem[28] = 8'h15; mem[29] = 8'hBC; mem[30] = 8'h9F; mem[31] = 8'hC0;
    sync_model();
    repeat (6) step();
    cycle(1'b0);
    check("pc_wrap", s_pc, 0);

    // Four wait states on FETCH and on STORE EXEC
    do_reset();
    wfix = 4;
    fill_nop(); mem[0] = 8'h39; d0 = 8'h5A; sync_model();
    step();
    check("store_val", mem[25], 8'h5A);
    wfix = 0;

    // HALT, then reset restarts fetch at 0
    do_reset();
    fill_nop(); mem[0] = 8'hE0; sync_model();
    step();
    check("halt_state", halted, 1);
    do_reset();
    fill_nop(); sync_model();
    step();

    // Async reset in the ack cycle of a LOAD's EXEC
    do_reset();
    fill_nop(); mem[0] = 8'h05; mem[5] = 8'h77; d0 = 8'h33; sync_model();
    do_txn("fetch", 0, 1'b0, 1'b0, 0, 1'b1);
    idle(1'b0);
    cycle(1'b0);
    check("arst_pre_req", s_req, 1);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = mem[mem_addr]; d0_q = d0;
    #1 check("arst_pre_d0we", d0_we, 1);
    #1 rst = 1'b1;
    #1;
    check("arst_req", mem_req, 0);
    check("arst_d0we", d0_we, 0);
    @(negedge clk);
    mem_ack = 1'b0;
    rst = 1'b0;
    check("arst_d0_kept", d0, 8'h33);
    mpc = 0; mhalt = 1'b0;
    step();

    // Randomized programs with random wait states
    wfix = -1; wmax = 3;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 32; i++) mem[i] = 8'($urandom_range(255, 0));
      d0 = 8'($urandom_range(3, 0) == 0 ? 0 : $urandom_range(255, 0));
      sync_model();
      for (int s = 0; s < 40 && !mhalt; s++) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
